stopwatch_div_ctrl: RTL
=======================

Name: stopwatch_div_ctrl

Overview:
Control-side partner of the 7-bit divider counter. It drives the counter's load / value-select / clear inputs and reads its count back. It runs the stopwatch state machine (IDLE / RUN / PAUSE) from the start-stop and clear buttons. On each counter wrap it emits a single-cycle tick, and it keeps a running total of ticks for the downstream display stage.

Parameters:
DIV_N, 100, counter terminal value; legal range 1..127; the counter cycles 1..DIV_N while running.
TICK_W, 16, width of the tick total counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en_in  in  1  prescale strobe, one clk cycle wide; the counter advances only on strobes
btn_start_stop  in  1  debounced, synchronised button level; rising edge toggles run/pause
btn_clear  in  1  debounced, synchronised button level; rising edge clears
cnt_val  in  7  current value from the divider counter
cnt_load  out  1  counter enable (counter acts only when high)
cnt_valsel  out  1  counter reload-to-1 select
cnt_clear  out  1  counter clear-to-0 select (priority over cnt_valsel inside the counter)
tick  out  1  one-cycle pulse per counter wrap
tick_cnt  out  TICK_W  total ticks since last clear, wraps modulo 2^TICK_W
running  out  1  high when state is RUN

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; ss_prev=0, clr_prev=0; tick=0; tick_cnt=0.
  - Button edges are masked while rst=1, so cnt_load, cnt_valsel, cnt_clear and running are all 0 during reset.
- Edge detection, combinational from registered previous levels:
  - ss_edge = btn_start_stop & ~ss_prev
  - clr_edge = btn_clear & ~clr_prev
  - ss_prev and clr_prev update every clk.
  - Holding a button high produces exactly one edge.
- State machine:
  - clr_edge in any state -> IDLE.
  - Otherwise ss_edge: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - No edge: hold state.
  - Simultaneous clr_edge and ss_edge: clear wins, next state IDLE, ss_edge is discarded.
- Counter control outputs are combinational, so the counter acts on the same clk edge:
  - cnt_clear = clr_edge
  - cnt_load = clr_edge | (state==RUN & en_in)
  - cnt_valsel = ~clr_edge & (cnt_val >= DIV_N)
- Count sequence:
  - Reload is to 1, so the steady tick period is exactly DIV_N strobes.
  - After a clear the counter is at 0, so the first period is DIV_N+1 strobes.
  - Any out-of-range cnt_val (>DIV_N, up to 127) reloads to 1 on the next strobe, with a tick.
- Run-state timing:
  - Decisions use the current state. en_in in the cycle of the IDLE->RUN ss_edge is ignored.
  - en_in in the cycle of the RUN->PAUSE ss_edge is still honoured.
  - running is a decode of the registered state.
- Tick: registered.
  - tick <= (state==RUN) & en_in & (cnt_val >= DIV_N) & ~clr_edge.
  - tick is high for exactly the one cycle after the counter's reload edge.
  - tick_cnt increments on the same clock edge that sets tick.
- tick_cnt:
  - Set to 0 on clr_edge; clear has priority over increment.
  - Wraps from 2^TICK_W-1 to 0 with no flag.
  - Holds its value in PAUSE and in IDLE.
- DIV_N=1: the counter sits at 1 and every strobe in RUN reloads it and produces a tick.
- Reset mid-run: all registers zero immediately (async); a pending tick is lost.
  - The counter has no reset, so the controller does not zero it. The first clear, or a run to DIV_N, normalises it.
- en_in high for consecutive cycles is legal; each cycle counts as one strobe.

Test Plan:
- Reset, then start edge, DIV_N=4, en_in every 2nd cycle:
  - from 0, first tick after 5 strobes; thereafter a tick every 4 strobes (8 cycles).
  - cnt_val sequence 1,2,3,4,1,...; tick_cnt 1,2,3.
- Run, then start-stop edge -> PAUSE:
  - cnt_load stays 0 despite en_in; cnt_val and tick_cnt frozen.
  - Second edge resumes counting from the held value with no extra tick.
- btn_clear edge while RUN at cnt_val=3, tick_cnt=7:
  - same cycle: cnt_clear=cnt_load=1, cnt_valsel=0.
  - next cycle: state IDLE, tick_cnt=0, running=0, tick=0.
- Simultaneous clear and start-stop edges from PAUSE -> IDLE, counter cleared.
  - Holding start-stop high afterwards produces no further transition.
- Force cnt_val=120 with DIV_N=10 in RUN:
  - next strobe cnt_valsel=1; tick pulses one cycle later; tick_cnt increments.
- TICK_W=4:
  - 16 ticks wraps tick_cnt 15->0.
  - rst asserted mid-period zeros tick/tick_cnt/state asynchronously, without waiting for clk.

Source files
------------

// File: rtl/stopwatch_div_ctrl.sv
// stopwatch_div_ctrl
// Control-side partner of an external 7-bit divider counter. Runs the
// IDLE / RUN / PAUSE stopwatch machine from two debounced button levels,
// steers the counter through load / reload-to-1 / clear-to-0 selects, and
// produces a one-cycle tick per counter wrap plus a running tick total.
//
// The counter itself has no reset. After a controller reset it may hold
// any value; the first clear, or a run up to DIV_N, brings it back into
// the 1..DIV_N cycle.
//
// DIV_N must lie in 1..127 so that it fits the counter's 7-bit value.

module stopwatch_div_ctrl #(
  parameter int DIV_N  = 100,
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              btn_start_stop,
  input  logic              btn_clear,
  input  logic [6:0]        cnt_val,
  output logic              cnt_load,
  output logic              cnt_valsel,
  output logic              cnt_clear,
  output logic              tick,
  output logic [TICK_W-1:0] tick_cnt,
  output logic              running
);

  // Terminal value at the counter's own width, so the compare is 7 bits
  // against 7 bits.
  localparam logic [6:0] DIV_N_V = 7'(DIV_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ss_prev_q, ss_prev_d;
  logic                clr_prev_q, clr_prev_d;
  logic                tick_q, tick_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;

  logic                ss_edge;
  logic                clr_edge;
  logic                at_term;
  logic                run_strobe;

  // Rising-edge detect against the previous button levels. Edges are
  // masked while rst is high, so the counter is never driven during reset.
  always_comb begin
    ss_prev_d  = btn_start_stop;
    clr_prev_d = btn_clear;
    ss_edge    = btn_start_stop & ~ss_prev_q  & ~rst;
    clr_edge   = btn_clear      & ~clr_prev_q & ~rst;
  end

  // Counter status decode: at or past the terminal value means the next
  // strobe reloads to 1. Out-of-range values (above DIV_N) land here too.
  always_comb begin
    at_term    = (cnt_val >= DIV_N_V);
    run_strobe = (state_q == ST_RUN) & en_in;
  end

  // Next-state logic: clear beats start/stop, and decisions use the
  // current state, so a strobe in the IDLE->RUN cycle is not counted.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    if (clr_edge) begin
      state_d = ST_IDLE;
    end else if (ss_edge) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Counter steering. Combinational so the counter acts on the same edge
  // as the controller's own registers.
  always_comb begin
    cnt_clear  = clr_edge;
    cnt_load   = clr_edge | run_strobe;
    cnt_valsel = ~rst & ~clr_edge & at_term;
  end

  // Tick and tick total. A wrap strobe sets tick for the cycle after the
  // reload edge; clear zeroes the total and suppresses any wrap that
  // coincides with it.
  always_comb begin
    tick_d     = run_strobe & at_term & ~clr_edge;
    tick_cnt_d = tick_cnt_q;
    if (clr_edge) begin
      tick_cnt_d = '0;
    end else if (tick_d) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  // State and history registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (rst) begin
      state_q    <= ST_IDLE;
      ss_prev_q  <= 1'b0;
      clr_prev_q <= 1'b0;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ss_prev_q  <= ss_prev_d;
      clr_prev_q <= clr_prev_d;
      tick_q     <= tick_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Registered outputs and the state decode.
  always_comb begin
    tick     = tick_q;
    tick_cnt = tick_cnt_q;
    running  = (state_q == ST_RUN);
  end

endmodule
